// File: rtl/bpsk_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bpsk_pkg - shared BPSK widths, sine table, FSM states            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package bpsk_pkg;

  localparam int DATA_WIDTH        = 12;
  localparam int SINE_RESOLUTION   = 6;
  localparam int CYCLES_PER_SYMBOL = 4;
  localparam int CARRIER_PERIOD    = 2 * SINE_RESOLUTION;
  localparam int N                 = CARRIER_PERIOD * CYCLES_PER_SYMBOL;
  localparam int PHASE_WIDTH       = $clog2(N);
  localparam int CARRIER_WIDTH     = $clog2(CARRIER_PERIOD);
  localparam int TABLE_IDX_WIDTH   = $clog2(SINE_RESOLUTION);
  localparam int PROD_WIDTH        = 2 * DATA_WIDTH;
  localparam int ACC_WIDTH         = PROD_WIDTH + $clog2(N);

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

  // Positive half-cycle of the carrier; the transmitter reads the same table.
  localparam sample_t SINE_TABLE [SINE_RESOLUTION] = '{
    sample_t'(0), sample_t'(1023), sample_t'(1772),
    sample_t'(2047), sample_t'(1772), sample_t'(1023)
  };

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    INTEGRATE = 1'b1
  } state_t;

  function automatic sample_t sine_ref(input logic [CARRIER_WIDTH-1:0] p);
    logic [CARRIER_WIDTH-1:0] q;
    sample_t r;
    if (p < CARRIER_WIDTH'(SINE_RESOLUTION)) begin
      r = SINE_TABLE[TABLE_IDX_WIDTH'(p)];
    end else begin
      q = p - CARRIER_WIDTH'(SINE_RESOLUTION);
      r = -SINE_TABLE[TABLE_IDX_WIDTH'(q)];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bpsk_demodulator_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bpsk_demodulator_if - sample input and bit output handshake      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface bpsk_demodulator_if;
  import bpsk_pkg::*;

  logic    sync;
  logic    sample_valid;
  sample_t sample;
  logic    bit_valid;
  logic    bit_ready;
  logic    bit_out;
  logic    overrun;
  logic    locked;

  modport master (
    output sync, sample_valid, sample, bit_ready,
    input  bit_valid, bit_out, overrun, locked
  );

  modport slave (
    input  sync, sample_valid, sample, bit_ready,
    output bit_valid, bit_out, overrun, locked
  );

endinterface
`default_nettype wire

// File: rtl/bpsk_integrator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bpsk_integrator - phase counter, reference MAC, symbol dump      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module bpsk_integrator
  import bpsk_pkg::*;
(
  input  wire logic    clk,
  input  wire logic    rst_n,
  input  wire logic    restart,
  input  wire logic    integrate,
  input  wire logic    sample_valid,
  input  wire sample_t sample,
  output logic         decision_valid,
  output logic         decision
);

  logic        [PHASE_WIDTH-1:0]   phase;
  logic        [CARRIER_WIDTH-1:0] carrier;
  logic signed [ACC_WIDTH-1:0]     acc;

  logic        [CARRIER_WIDTH-1:0] carrier_sel;
  logic        [CARRIER_WIDTH-1:0] carrier_next;
  logic signed [PROD_WIDTH-1:0]    prod;
  logic signed [ACC_WIDTH-1:0]     sum;
  logic                            last;

  // A restart sample is always taken as phase 0, whatever the counters hold.
  always_comb begin
    carrier_sel    = restart ? '0 : carrier;
    carrier_next   = (carrier_sel == CARRIER_WIDTH'(CARRIER_PERIOD - 1))
                     ? '0 : carrier_sel + 1'b1;
    prod           = PROD_WIDTH'(sample) * PROD_WIDTH'(sine_ref(carrier_sel));
    sum            = acc + ACC_WIDTH'(prod);
    last           = (phase == PHASE_WIDTH'(N - 1));
    decision_valid = integrate && sample_valid && !restart && last;
    decision       = !sum[ACC_WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= '0;
      carrier <= '0;
      acc     <= '0;
    end else if (restart) begin
      phase   <= sample_valid ? PHASE_WIDTH'(1) : '0;
      carrier <= sample_valid ? carrier_next : '0;
      acc     <= sample_valid ? ACC_WIDTH'(prod) : '0;
    end else if (integrate && sample_valid) begin
      carrier <= carrier_next;
      if (last) begin
        phase <= '0;
        acc   <= '0;
      end else begin
        phase <= phase + 1'b1;
        acc   <= sum;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bpsk_demodulator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bpsk_demodulator - coherent BPSK receiver, one bit per symbol    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module bpsk_demodulator
  import bpsk_pkg::*;
(
  input  wire logic           clk,
  input  wire logic           rst_n,
  bpsk_demodulator_if.slave   bus
);

  state_t state;
  state_t next_state;
  logic   locked;
  logic   decision_valid;
  logic   decision;
  logic   held_valid;
  logic   held_bit;
  logic   overrun_flag;

  bpsk_integrator u_integrator (
    .clk            (clk),
    .rst_n          (rst_n),
    .restart        (bus.sync),
    .integrate      (locked),
    .sample_valid   (bus.sample_valid),
    .sample         (bus.sample),
    .decision_valid (decision_valid),
    .decision       (decision)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (bus.sync) next_state = INTEGRATE;
      INTEGRATE: next_state = INTEGRATE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    locked = (state == INTEGRATE);
  end

  // A full holding register with no taker drops the new decision, not the old one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_valid   <= 1'b0;
      held_bit     <= 1'b0;
      overrun_flag <= 1'b0;
    end else begin
      if (decision_valid) begin
        if (!held_valid || bus.bit_ready) begin
          held_valid <= 1'b1;
          held_bit   <= decision;
        end else begin
          overrun_flag <= 1'b1;
        end
      end else if (held_valid && bus.bit_ready) begin
        held_valid <= 1'b0;
      end
      if (bus.sync) overrun_flag <= 1'b0;
    end
  end

  assign bus.bit_valid = held_valid;
  assign bus.bit_out   = held_bit;
  assign bus.overrun   = overrun_flag;
  assign bus.locked    = locked;

endmodule
`default_nettype wire

// File: tb/tb_bpsk_demodulator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_bpsk_demodulator - scoreboard bench for the BPSK receiver     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_bpsk_demodulator;
  import bpsk_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  bpsk_demodulator_if bus();

  bpsk_demodulator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  int tbl[SINE_RESOLUTION] = '{0, 1023, 1772, 2047, 1772, 1023};

  function automatic int ref_model(input int k);
    int p;
    p = k % (2 * SINE_RESOLUTION);
    return (p < SINE_RESOLUTION) ? tbl[p] : -tbl[p - SINE_RESOLUTION];
  endfunction

  // Advance one cycle; a transfer seen mid-cycle is matched against the scoreboard.
  task automatic step();
    bit exp_bit;
    @(negedge clk);
    if (bus.bit_valid && bus.bit_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected: got bit %0b, none expected", bus.bit_out);
      end else begin
        exp_bit = exp_q.pop_front();
        if (bus.bit_out !== exp_bit) begin
          errors++;
          $display("FAIL scoreboard_bit: got %0b expected %0b", bus.bit_out, exp_bit);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_symbol(input bit b, input bit with_sync, input int gap_max,
                             input int count, input bit push);
    int v;
    for (int k = 0; k < count; k++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          bus.sample_valid = 1'b0;
          bus.sync         = 1'b0;
          step();
        end
      end
      v = b ? ref_model(k) : -ref_model(k);
      bus.sample_valid = 1'b1;
      bus.sync         = with_sync && (k == 0);
      bus.sample       = sample_t'(v);
      if (push && k == N - 1) exp_q.push_back(b);
      step();
    end
    bus.sample_valid = 1'b0;
    bus.sync         = 1'b0;
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    bus.sync         = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample       = '0;
    bus.bit_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    checks += 4;
    if (bus.bit_valid !== 1'b0) begin errors++; $display("FAIL reset_bit_valid: got %0b expected 0", bus.bit_valid); end
    if (bus.bit_out   !== 1'b0) begin errors++; $display("FAIL reset_bit_out: got %0b expected 0", bus.bit_out); end
    if (bus.overrun   !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b expected 0", bus.overrun); end
    if (bus.locked    !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b expected 0", bus.locked); end
  endtask

  task automatic test_idle(input int cycles);
    bus.bit_ready = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      bus.sample_valid = 1'($urandom_range(0, 1));
      bus.sample       = sample_t'($urandom_range(0, 4095));
      step();
      checks++;
      if (bus.bit_valid !== 1'b0 || bus.locked !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet: got valid %0b locked %0b expected 0 0", bus.bit_valid, bus.locked);
      end
    end
    bus.sample_valid = 1'b0;
  endtask

  task automatic test_single_symbol();
    logic signed [ACC_WIDTH-1:0] exp_sum;
    exp_sum = ACC_WIDTH'(100505880);
    bus.bit_ready = 1'b1;
    send_symbol(1'b1, 1'b1, 0, N - 1, 1'b0);
    checks += 2;
    if (bus.locked !== 1'b1) begin errors++; $display("FAIL single_locked: got %0b expected 1", bus.locked); end
    if (bus.bit_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0b expected 0", bus.bit_valid); end
    bus.sample_valid = 1'b1;
    bus.sample       = sample_t'(ref_model(N - 1));
    #1;
    checks++;
    if (dut.u_integrator.sum !== exp_sum) begin
      errors++;
      $display("FAIL single_sum: got %0d expected %0d", dut.u_integrator.sum, exp_sum);
    end
    exp_q.push_back(1'b1);
    step();
    bus.sample_valid = 1'b0;
    checks++;
    if (bus.bit_valid !== 1'b1 || bus.bit_out !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: got valid %0b bit %0b expected 1 1", bus.bit_valid, bus.bit_out);
    end
    step();
  endtask

  task automatic test_stream();
    bit pattern[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bus.bit_ready = 1'b1;
    foreach (pattern[i]) send_symbol(pattern[i], 1'b0, 2, N, 1'b1);
    repeat (3) step();
    checks += 2;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stream_drained: got %0d pending expected 0", exp_q.size()); end
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL stream_overrun: got %0b expected 0", bus.overrun); end
  endtask

  task automatic test_overrun();
    bus.bit_ready = 1'b0;
    send_symbol(1'b1, 1'b0, 0, N, 1'b1);
    send_symbol(1'b0, 1'b0, 0, N, 1'b0);
    step();
    checks += 3;
    if (bus.bit_valid !== 1'b1) begin errors++; $display("FAIL overrun_held_valid: got %0b expected 1", bus.bit_valid); end
    if (bus.bit_out   !== 1'b1) begin errors++; $display("FAIL overrun_held_bit: got %0b expected 1", bus.bit_out); end
    if (bus.overrun   !== 1'b1) begin errors++; $display("FAIL overrun_set: got %0b expected 1", bus.overrun); end
    bus.bit_ready = 1'b1;
    step();
    checks += 2;
    if (bus.bit_valid !== 1'b0) begin errors++; $display("FAIL overrun_delivered: got %0b expected 0", bus.bit_valid); end
    if (bus.overrun   !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %0b expected 1", bus.overrun); end
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    checks++;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL overrun_cleared: got %0b expected 0", bus.overrun); end
  endtask

  task automatic test_sync_abort();
    bus.bit_ready = 1'b1;
    send_symbol(1'b1, 1'b0, 0, 30, 1'b0);
    send_symbol(1'b0, 1'b1, 0, N, 1'b1);
    checks++;
    if (bus.bit_valid !== 1'b1 || bus.bit_out !== 1'b0) begin
      errors++;
      $display("FAIL abort_next_decision: got valid %0b bit %0b expected 1 0", bus.bit_valid, bus.bit_out);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bus.bit_ready = 1'b0;
    send_symbol(1'b1, 1'b0, 0, N, 1'b0);
    send_symbol(1'b1, 1'b0, 0, 10, 1'b0);
    checks++;
    if (bus.bit_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pending: got %0b expected 1", bus.bit_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.bit_valid, bus.bit_out, bus.overrun, bus.locked} !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_async_clear: got %b expected 0000",
               {bus.bit_valid, bus.bit_out, bus.overrun, bus.locked});
    end
    step();
    rst_n = 1'b1;
    bus.bit_ready = 1'b1;
    for (int i = 0; i < N + 12; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample       = sample_t'(ref_model(i));
      step();
      checks++;
      if (bus.bit_valid !== 1'b0 || bus.locked !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_idle: got valid %0b locked %0b expected 0 0", bus.bit_valid, bus.locked);
      end
    end
    bus.sample_valid = 1'b0;
    send_symbol(1'b0, 1'b1, 0, N, 1'b1);
    checks++;
    if (bus.bit_valid !== 1'b1 || bus.bit_out !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_resync: got valid %0b bit %0b expected 1 0", bus.bit_valid, bus.bit_out);
    end
  endtask

  initial begin
    test_reset();
    test_idle(200);
    test_single_symbol();
    test_stream();
    test_overrun();
    test_sync_abort();
    test_reset_mid();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bpsk_demodulator.md
# bpsk_demodulator

Coherent BPSK receiver: consumes signed carrier samples at one sample per sample-valid strobe, correlates each symbol period against the internal sine reference, and emits one hard-decided bit per symbol through a valid/ready output register. It is the receive-side counterpart of the team's sine wave-table BPSK transmit path and sits between the sample source (ADC front end or loopback) and the bit sink/framer. Carrier phase and symbol timing are aligned externally by a `sync` strobe; no carrier or timing recovery is done here.

## Interface
- `DATA_WIDTH`, from `parameters.svh`: sample and reference width (signed two's complement).
- `SINE_RESOLUTION`, from `parameters.svh`: samples per carrier half-cycle (default 6; full cycle = 12).
- `CYCLES_PER_SYMBOL`, 4: carrier cycles per symbol; N = 2*SINE_RESOLUTION*CYCLES_PER_SYMBOL samples per symbol.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sync`  in  1  symbol/carrier alignment strobe.
- `sample_valid`  in  1  `sample` is valid this cycle.
- `sample`  in  DATA_WIDTH signed  received carrier sample.
- `bit_valid`  out  1  `bit_out` holds an undelivered decision.
- `bit_ready`  in  1  sink accepts `bit_out`.
- `bit_out`  out  1  decided bit.
- `overrun`  out  1  sticky: a decision was dropped.
- `locked`  out  1  FSM in INTEGRATE.

## Operation
- Reset values: `bit_valid`=0, `bit_out`=0, `overrun`=0, `locked`=0, accumulator=0, phase=0, FSM=IDLE.
- FSM IDLE: samples ignored. `sync`=1 goes to INTEGRATE; phase and accumulator restart as described below.
- FSM INTEGRATE: on each `sample_valid`, acc += sample * ref(phase mod 2*SINE_RESOLUTION); phase increments and wraps at N-1 → 0.
- ref(p): table value for p < SINE_RESOLUTION, negated table[p-SINE_RESOLUTION] otherwise. The table is identical to the transmit table (0,1023,1772,2047,1772,1023 at the default width).
- Decision: on the accepted sample with phase N-1, bit = 1 if the final sum (including that sample) is ≥ 0, else 0. Accumulator is cleared. Tie (sum = 0) decides 1.
- Mapping: bit 1 = carrier in phase with reference; bit 0 = inverted carrier. This matches the transmitter.
- Widths: product 2*DATA_WIDTH signed. ACC_WIDTH = 2*DATA_WIDTH + $clog2(N) signed; no saturation is needed.
- `sync` in INTEGRATE: the accumulator is discarded, phase resets, and no decision is made. A sample valid in the `sync` cycle is accumulated as phase 0. This also applies in IDLE.
- `sync` coincident with phase N-1: `sync` wins and no decision is made.
- `sync` clears `overrun`. It does not affect a pending `bit_valid`.
- No exit from INTEGRATE except reset.

## Timing
- Latency: last sample accepted in cycle t → `bit_valid`=1 with the new `bit_out` in cycle t+1.
- Handshake: transfer occurs when `bit_valid` && `bit_ready`. `bit_out` is stable while `bit_valid`=1.
- Decision completes in a cycle where `bit_valid`=1 and `bit_ready`=1: the new bit loads and `bit_valid` stays 1, with no bubble.
- Decision completes in a cycle where `bit_valid`=1 and `bit_ready`=0: the new bit is dropped, the held bit is kept, and `overrun` is set from the next cycle.
- `bit_ready` may be high while `bit_valid`=0 with no effect.
- `sample_valid` gaps stall phase and accumulator only. Back-to-back samples every cycle must be sustained.
- `rst_n` asserted mid-symbol or with `bit_valid` high clears all state immediately (asynchronous assertion); the pending bit is lost.

## Structure
- Shared package `bpsk_pkg`: ACC_WIDTH and N derivation, sine table constant (single source shared with the transmitter), and FSM enum `{IDLE, INTEGRATE}`.
- One sub-module, `bpsk_integrator`: phase counter, reference lookup, MAC, and dump/clear, producing a `decision_valid` pulse and `decision` bit.
- Top level: FSM, output register/handshake, and overrun logic.

## Test plan
- Reset then idle: no `sync`, 200 random samples → `bit_valid`=0, `locked`=0 throughout.
- `sync` then 48 samples equal to ref(phase) (one symbol at defaults) → single `bit_out`=1 one cycle after the 48th sample; internal sum = 100505880.
- Symbols 1,0,1,1 with inverted carrier for 0, `bit_ready`=1, `sample_valid` randomly gapped → outputs 1,0,1,1 in order, no `overrun`.
- `bit_ready`=0 across two completed symbols (1 then 0) → `bit_out` remains 1 and `overrun`=1. Assert `bit_ready`, then `sync` → bit 1 is delivered and `overrun` clears.
- `sync` at sample 30 of a symbol, then 48 inverted samples → no decision from the aborted symbol; the next decision is 0, 48 samples after the `sync` cycle.
- Assert `rst_n` low while `bit_valid`=1 mid-symbol → all outputs 0 immediately; FSM returns to IDLE and waits for `sync`.
